restoring_divider: RTL

//   Sequential unsigned restoring divider. Computes dividend / divisor one quotient bit per clock.

---
 rtl/restoring_divider_if.sv | 24 ++
 rtl/restoring_divider.sv | 133 +++++++++++++
 2 files changed

// File: rtl/restoring_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the restoring divider.
// The master drives the request side; the divider is the slave.
interface restoring_divider_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are registered on entry to DONE and held until the next DONE.
module restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    restoring_divider_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]    r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              dbz_q, dbz_d;

    logic [2*WIDTH:0]  rq_shift;
    logic [WIDTH:0]    r_sh;
    logic [WIDTH-1:0]  q_sh;
    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    r_next;
    logic [WIDTH-1:0]  q_next;

    // One iteration: shift {R,Q}, trial-subtract D, keep the result only when it did not borrow.
    always_comb begin
        rq_shift = {r_q, q_q} << 1;
        r_sh     = rq_shift[2*WIDTH:WIDTH];
        q_sh     = rq_shift[WIDTH-1:0];
        trial    = r_sh + ~{1'b0, d_q} + (WIDTH+1)'(1);
        if (!trial[WIDTH]) begin
            r_next = trial;
            q_next = {q_sh[WIDTH-1:1], 1'b1};
        end else begin
            r_next = r_sh;
            q_next = q_sh;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    d_d   = bus.divisor;
                    q_d   = bus.dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StRun;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = r_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
